// File: rtl/forney_err_apply.sv
// Forney S3: gathers (position, value) error pairs into a T-entry table, then XORs them into the streamed codeword.
// Optional duplicate-position detection under `FORNEY_ERR_APPLY_DUP_CHECK_EN.
module forney_err_apply #(
  parameter int W     = 10,
  parameter int POS_W = 10,
  parameter int N     = 544,
  parameter int T     = 15,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s2_vld_i,
  output logic             s3_rdy_o,
  input  logic [POS_W-1:0] pos_i,
  input  logic [W-1:0]     y_i,
  input  logic             den_zero_i,
  input  logic             s2_recorrect_done_i,
  input  logic             din_vld_i,
  output logic             din_rdy_o,
  input  logic [W-1:0]     din_i,
  input  logic             din_last_i,
  output logic             dout_vld_o,
  input  logic             dout_rdy_i,
  output logic [W-1:0]     dout_o,
  output logic             dout_last_o,
  output logic             stat_vld_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int IDX_W = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {COLLECT, CORRECT, REPORT} state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] tbl_pos [T];
  logic [W-1:0]     tbl_y   [T];
  logic [CNT_W-1:0] count;
  logic [POS_W-1:0] idx;
  logic             fail_pend;
  logic             len_err;
  logic             done_q;
  logic             done_edge;
  logic             entry_acc;
  logic             din_acc;
  logic             idx_end;
  logic             last_acc;
  logic             tbl_full;
  logic             dup_hit;
  logic [W-1:0]     corr;

  assign done_edge = !done_q && s2_recorrect_done_i;
  assign entry_acc = s2_vld_i && s3_rdy_o;
  assign din_acc   = din_vld_i && din_rdy_o;
  assign idx_end   = (idx == POS_W'(N - 1));
  assign last_acc  = din_acc && (din_last_i || idx_end);
  assign tbl_full  = (count >= CNT_W'(T));

`ifdef FORNEY_ERR_APPLY_DUP_CHECK_EN
  always_comb begin
    dup_hit = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (CNT_W'(k) < count && tbl_pos[k] == pos_i) dup_hit = 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // Duplicate positions accumulate, so every matching valid entry contributes.
  always_comb begin
    corr = '0;
    for (int k = 0; k < T; k++) begin
      if (CNT_W'(k) < count && tbl_pos[k] == idx) corr = corr ^ tbl_y[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= COLLECT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (done_edge) state_nxt = CORRECT;
      CORRECT: if (last_acc)  state_nxt = REPORT;
      REPORT:  state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    s3_rdy_o  = (state == COLLECT) && !rst_i;
    din_rdy_o = (state == CORRECT) && (!dout_vld_o || dout_rdy_i);
  end

  always_ff @(posedge clk_i) begin
    if (state == COLLECT && entry_acc && !tbl_full) begin
      tbl_pos[count[IDX_W-1:0]] <= pos_i;
      tbl_y[count[IDX_W-1:0]]   <= y_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q      <= 1'b1;
      count       <= '0;
      idx         <= '0;
      fail_pend   <= 1'b0;
      len_err     <= 1'b0;
      dout_vld_o  <= 1'b0;
      dout_o      <= '0;
      dout_last_o <= 1'b0;
      stat_vld_o  <= 1'b0;
      fail_o      <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      done_q     <= s2_recorrect_done_i;
      stat_vld_o <= (state == REPORT);

      if (state == COLLECT && entry_acc) begin
        if (!tbl_full) count <= count + CNT_W'(1);
        if (tbl_full || den_zero_i || dup_hit) fail_pend <= 1'b1;
      end

      if (din_acc) begin
        idx         <= idx + POS_W'(1);
        dout_o      <= fail_pend ? din_i : (din_i ^ corr);
        dout_vld_o  <= 1'b1;
        dout_last_o <= din_last_i || idx_end;
      end else if (dout_rdy_i) begin
        dout_vld_o <= 1'b0;
      end

      if (last_acc) len_err <= (din_last_i != idx_end);

      if (state == REPORT) begin
        fail_o    <= fail_pend || len_err;
        err_cnt_o <= count;
        count     <= '0;
        idx       <= '0;
        fail_pend <= 1'b0;
        len_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_forney_err_apply.sv
// Randomised bench for forney_err_apply: a queue-based model derives the corrected stream and status
// from the entry list; one monitor compares every transferred beat and status pulse.
module tb_forney_err_apply;
  localparam int W = 10, POS_W = 10, N = 544, T = 15, CNT_W = 5;

  logic             clk = 1'b0, rst = 1'b1;
  logic             s2_vld = 1'b0, s3_rdy;
  logic [POS_W-1:0] pos = '0;
  logic [W-1:0]     y = '0;
  logic             den_zero = 1'b0, done = 1'b0;
  logic             din_vld = 1'b0, din_rdy, din_last = 1'b0;
  logic [W-1:0]     din = '0;
  logic             dout_vld, dout_rdy = 1'b1, dout_last;
  logic [W-1:0]     dout;
  logic             stat_vld, fail;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  forney_err_apply #(.W(W), .POS_W(POS_W), .N(N), .T(T), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .s2_vld_i(s2_vld), .s3_rdy_o(s3_rdy), .pos_i(pos), .y_i(y),
    .den_zero_i(den_zero), .s2_recorrect_done_i(done), .din_vld_i(din_vld), .din_rdy_o(din_rdy),
    .din_i(din), .din_last_i(din_last), .dout_vld_o(dout_vld), .dout_rdy_i(dout_rdy), .dout_o(dout),
    .dout_last_o(dout_last), .stat_vld_o(stat_vld), .fail_o(fail), .err_cnt_o(err_cnt));

  int n_cmp = 0, n_err = 0, rdy_mode = 0, mbase = 0;
  int ent_pos[$], ent_y[$];
  bit ent_dz[$];
  logic [W-1:0] din_arr [N];
  logic [W-1:0] exp_dat[$];
  bit exp_last[$], exp_fail[$];
  int exp_cnt[$];

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Downstream ready: always-on, alternating, or random.
  always @(negedge clk) begin
    case (rdy_mode)
      0: dout_rdy = 1'b1;
      1: dout_rdy = ~dout_rdy;
      default: dout_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor samples between edges, predicting the transfer at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (dout_vld && dout_rdy) begin
        if (exp_dat.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("dout", int'(dout), int'(exp_dat.pop_front()));
          chk("dout_last", int'(dout_last), int'(exp_last.pop_front()));
        end
      end
      if (dout_vld && !dout_rdy) chk("din_stall", int'(din_rdy), 0);
      if (stat_vld) begin
        if (exp_cnt.size() == 0) chk("unexpected_stat", 1, 0);
        else begin
          chk("err_cnt", int'(err_cnt), exp_cnt.pop_front());
          chk("fail", int'(fail), int'(exp_fail.pop_front()));
        end
      end
    end
  end

  // Expected output of one codeword, derived from the entry list and stream length.
  task automatic build_model(input int last_at);
    int n, st, e;
    bit fp, le;
    logic [W-1:0] c;
    n  = ent_pos.size();
    st = (n > T) ? T : n;
    fp = (n > T);
    foreach (ent_dz[j]) if (ent_dz[j]) fp = 1'b1;
`ifdef FORNEY_ERR_APPLY_DUP_CHECK_EN
    for (int j = 0; j < st; j++)
      for (int k = 0; k < j; k++)
        if (ent_pos[j] == ent_pos[k]) fp = 1'b1;
`endif
    e  = (last_at >= 0 && last_at < N - 1) ? last_at : N - 1;
    le = (last_at != N - 1);
    mbase = exp_dat.size();
    for (int i = 0; i <= e; i++) begin
      c = '0;
      if (!fp)
        for (int k = 0; k < st; k++)
          if (ent_pos[k] == i) c = c ^ W'(ent_y[k]);
      exp_dat.push_back(din_arr[i] ^ c);
      exp_last.push_back(i == e);
    end
    exp_cnt.push_back(st);
    exp_fail.push_back(fp | le);
  endtask

  task automatic wait_acc(input bit is_din, input string nm);
    int t = 0;
    while (1) begin
      #1;
      if (is_din ? din_rdy : s3_rdy) begin
        @(posedge clk);
        return;
      end
      t++;
      if (t > 3000) begin
        chk({nm, "_timeout"}, 1, 0);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drive_cw(input int last_at, input int abort_after);
    int n, e, nsym;
    n    = ent_pos.size();
    e    = (last_at >= 0 && last_at < N - 1) ? last_at : N - 1;
    nsym = (abort_after >= 0) ? abort_after : e + 1;
    if (n == 0) begin
      @(negedge clk);
      done = 1'b1;
      @(posedge clk);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      s2_vld = 1'b1; pos = POS_W'(ent_pos[j]); y = W'(ent_y[j]); den_zero = ent_dz[j];
      if (j == n - 1) done = 1'b1;  // done edge coincides with the final entry
      wait_acc(1'b0, "entry");
    end
    @(negedge clk);
    s2_vld = 1'b0; den_zero = 1'b0;
    for (int i = 0; i < nsym; i++) begin
      if (i > 0) @(negedge clk);
      din_vld = 1'b1; din = din_arr[i]; din_last = (i == last_at);
      wait_acc(1'b1, "din");
    end
    @(negedge clk);
    din_vld = 1'b0; din_last = 1'b0; done = 1'b0;
    if (abort_after >= 0) begin
      rst = 1'b1;
      #2;
      chk("rst_dout_vld", int'(dout_vld), 0);
      chk("rst_s3_rdy", int'(s3_rdy), 0);
      chk("rst_din_rdy", int'(din_rdy), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      exp_dat.delete(); exp_last.delete();
      void'(exp_cnt.pop_back()); void'(exp_fail.pop_back());
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_entries();
    ent_pos.delete(); ent_y.delete(); ent_dz.delete();
  endtask

  task automatic add_entry(input int p, input int v, input bit dz);
    ent_pos.push_back(p); ent_y.push_back(v); ent_dz.push_back(dz);
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din_arr[i] = W'($urandom_range(0, (1 << W) - 1));
  endtask

  initial begin
    int sel, la, ne;
    #3;
    chk("reset_s3_rdy", int'(s3_rdy), 0);
    chk("reset_din_rdy", int'(din_rdy), 0);
    chk("reset_dout_vld", int'(dout_vld), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_dout_last", int'(dout_last), 0);
    chk("reset_stat_vld", int'(stat_vld), 0);
    chk("reset_fail", int'(fail), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("collect_s3_rdy", int'(s3_rdy), 1);

    // three corrections on an all-zero stream
    clear_entries();
    add_entry(0, 'h3FF, 0); add_entry(100, 'h001, 0); add_entry(543, 'h2A5, 0);
    for (int i = 0; i < N; i++) din_arr[i] = '0;
    build_model(N - 1);
    chk("pin_d0", int'(exp_dat[mbase]), 'h3FF);
    chk("pin_d100", int'(exp_dat[mbase + 100]), 'h001);
    chk("pin_d543", int'(exp_dat[mbase + 543]), 'h2A5);
    chk("pin_d1", int'(exp_dat[mbase + 1]), 0);
    chk("pin_last543", int'(exp_last[mbase + 543]), 1);
    chk("pin_cnt3", exp_cnt[exp_cnt.size() - 1], 3);
    chk("pin_ok", int'(exp_fail[exp_fail.size() - 1]), 0);
    drive_cw(N - 1, -1);

    // table overflow
    clear_entries();
    for (int j = 0; j < 16; j++) add_entry(j * 30, $urandom_range(1, 1023), 0);
    rand_din();
    build_model(N - 1);
    chk("pin_ovf_cnt", exp_cnt[exp_cnt.size() - 1], 15);
    chk("pin_ovf_fail", int'(exp_fail[exp_fail.size() - 1]), 1);
    chk("pin_ovf_pass", int'(exp_dat[mbase + 30]), int'(din_arr[30]));
    drive_cw(N - 1, -1);

    // zero denominator
    clear_entries();
    add_entry(20, 'h155, 1);
    rand_din();
    build_model(N - 1);
    chk("pin_dz_fail", int'(exp_fail[exp_fail.size() - 1]), 1);
    chk("pin_dz_pass", int'(exp_dat[mbase + 20]), int'(din_arr[20]));
    drive_cw(N - 1, -1);

    // alternating downstream ready
    rdy_mode = 1;
    clear_entries();
    for (int j = 0; j < 5; j++) add_entry($urandom_range(0, N - 1), $urandom_range(1, 1023), 0);
    rand_din();
    build_model(N - 1);
    drive_cw(N - 1, -1);
    rdy_mode = 0;

    // early last, then an empty codeword
    clear_entries();
    add_entry(10, 'h0F0, 0);
    rand_din();
    build_model(300);
    chk("pin_early_len", exp_dat.size() - mbase, 301);
    chk("pin_early_fail", int'(exp_fail[exp_fail.size() - 1]), 1);
    drive_cw(300, -1);
    clear_entries();
    rand_din();
    build_model(N - 1);
    chk("pin_empty_cnt", exp_cnt[exp_cnt.size() - 1], 0);
    chk("pin_empty_fail", int'(exp_fail[exp_fail.size() - 1]), 0);
    drive_cw(N - 1, -1);

    // duplicate positions
    clear_entries();
    add_entry(7, 'h005, 0); add_entry(7, 'h003, 0);
    rand_din();
    build_model(N - 1);
`ifdef FORNEY_ERR_APPLY_DUP_CHECK_EN
    chk("pin_dup_fail", int'(exp_fail[exp_fail.size() - 1]), 1);
    chk("pin_dup_d7", int'(exp_dat[mbase + 7]), int'(din_arr[7]));
`else
    chk("pin_dup_fail", int'(exp_fail[exp_fail.size() - 1]), 0);
    chk("pin_dup_d7", int'(exp_dat[mbase + 7]), int'(din_arr[7] ^ 10'h006));
`endif
    drive_cw(N - 1, -1);

    // no din_last by the final index
    clear_entries();
    add_entry(543, 'h3C3, 0);
    rand_din();
    build_model(-1);
    drive_cw(-1, -1);

    // randomised codewords
    for (int r = 0; r < 8; r++) begin
      clear_entries();
      rdy_mode = $urandom_range(0, 2);
      ne = $urandom_range(0, 17);
      for (int j = 0; j < ne; j++)
        add_entry(($urandom_range(0, 9) == 0) ? $urandom_range(N, 1023) : $urandom_range(0, N - 1),
                  $urandom_range(1, 1023), $urandom_range(0, 19) == 0);
      rand_din();
      sel = $urandom_range(0, 9);
      la  = (sel < 7) ? N - 1 : (sel < 9) ? $urandom_range(0, N - 2) : -1;
      build_model(la);
      drive_cw(la, -1);
    end
    rdy_mode = 0;

    // reset in the middle of a stream, then a clean codeword
    clear_entries();
    add_entry(3, 'h111, 0);
    rand_din();
    build_model(N - 1);
    drive_cw(N - 1, 50);
    clear_entries();
    add_entry(5, 'h2B2, 0);
    rand_din();
    build_model(N - 1);
    drive_cw(N - 1, -1);

    for (int t = 0; t < 3000 && (exp_dat.size() != 0 || exp_cnt.size() != 0); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_beats", exp_dat.size(), 0);
    chk("drain_stat", exp_cnt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
